drive_arbiter: RTL
==================

Name: drive_arbiter

Overview:
- Owns the two motor PWM duty/direction channels and decides which requester drives them: the IR remote path or the camera follow path.
- The requester is chosen by the top-level mode (IDLE/CAM/IR) from the mode FSM.
- Converts the winning 3-bit drive command and current gear into per-wheel target duty, and ramps the actual duty toward that target.
- Enforces e-stop, a command watchdog, and safe ramp-down on mode or direction changes. Sits between the mode FSM and the PWM generators.

Parameters:
- RAMP_DIV, 4, clock cycles between ramp ticks (>=1).
- RAMP_STEP, 16, maximum duty change per wheel per ramp tick (1..255).
- TIMEOUT, 1000, cycles without a valid command from the granted source before its command is forced to STOP.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  0=IDLE, 1=CAM, 2=IR, 3 treated as IDLE.
- ir_valid  in  1  one-cycle strobe: ir_cmd is a new IR command.
- ir_cmd  in  3  IR drive command.
- cam_valid  in  1  one-cycle strobe: cam_cmd is a new camera command.
- cam_cmd  in  3  camera drive command.
- gear  in  2  0..3; sets the base speed.
- estop  in  1  obstacle too close; level-sensitive.
- duty_l  out  8  left wheel duty.
- duty_r  out  8  right wheel duty.
- dir_l  out  1  left wheel direction, 1=forward.
- dir_r  out  1  right wheel direction, 1=forward.
- grant  out  2  0=none, 1=CAM, 2=IR.
- busy  out  1  high in SWITCH or ESTOP.

Behaviour:
- Reset: duty_l=duty_r=0, dir_l=dir_r=1, grant=0, busy=0, state=IDLE, latched cmd=STOP, ramp and watchdog counters=0.
- Command codes: 0=STOP, 1=FWD, 2=SPIN_L, 3=SPIN_R, 4=ARC_L, 5=ARC_R, 6=REV, 7 treated as STOP.
- Base speed S = gear*64+63, giving 63, 127, 191, 255.
- Targets as (left duty/dir ; right duty/dir):
  - FWD: S/F ; S/F.
  - REV: S/R ; S/R.
  - SPIN_L: S/R ; S/F.
  - SPIN_R: S/F ; S/R.
  - ARC_L: S>>1/F ; S/F.
  - ARC_R: S/F ; S>>1/F.
  - STOP: 0 on both wheels, direction unchanged.
- Latch:
  - Only the granted source's valid strobe loads the latched cmd, on the next edge. The other source is ignored.
  - Every accepted strobe clears the watchdog.
  - When the watchdog reaches TIMEOUT, latched cmd becomes STOP and the watchdog holds.
- States:
  - IDLE: grant=0, target 0. If mode is CAM or IR, go to RUN with grant=mode and latched cmd=STOP.
  - RUN: target derived from the latched cmd.
    - If mode differs from grant, go to SWITCH. This includes a change to IDLE.
    - If estop=1, go to ESTOP. ESTOP has priority over SWITCH in the same cycle.
  - SWITCH: grant=0, target 0, normal ramp down.
    - When duty_l=duty_r=0, go to IDLE. IDLE re-grants the new mode on the next cycle.
    - estop=1 goes to ESTOP.
  - ESTOP: duty_l and duty_r are forced to 0 on the first ESTOP edge, with no ramp. grant=0 and latched cmd=STOP.
    - Leave for IDLE only when estop=0 and a STOP command has been seen from the mode-selected source (ir_cmd or cam_cmd) while estop=0.
- Ramp:
  - A tick occurs once every RAMP_DIV cycles from a free-running counter.
  - On a tick, each wheel moves toward its effective target by min(RAMP_STEP, |target−duty|). There is no overshoot and no 8-bit wrap.
  - Between ticks, duty holds.
- Direction change:
  - If a wheel's target dir differs from its dir, that wheel's effective target is 0.
  - In the cycle that wheel's duty is 0, dir takes the target dir. Ramping up starts on the next tick.
- Simultaneous events:
  - ir_valid and cam_valid together: only the granted one counts.
  - A strobe in the cycle the timeout is reached: the strobe wins and the watchdog clears.
  - A gear change mid-ramp only retargets; no state change.
- Reset mid-ramp: outputs return to reset values on the next edge.

Test Plan:
- Reset, mode=2, ir strobe FWD, gear=3 -> grant=2; duty_l/r rise 0,16,32,...,255 every 4 cycles; final step 240→255; dir=1.
- Running FWD at duty 255, IR strobe REV -> both wheels ramp to 0, dir flips to 0 at zero, then ramp to 255.
- Running at duty 127, mode 2→1 -> busy=1, grant=0, ramp to 0, IDLE, then grant=1 with duty 0; IR strobes are now ignored.
- Running, estop=1 -> duty 0 on the next edge, busy=1. Drop estop, send IR FWD -> stays ESTOP. Send IR STOP -> IDLE, then RUN.
- Running ARC_L at gear 1 (63/127), no strobes for 1000 cycles -> cmd forced STOP, ramp to 0. A strobe at exactly cycle 1000 keeps the motion.
- Send cmd code 7 -> treated as STOP. Toggle gear mid-ramp -> target tracks without overshoot.

Source files
------------

// File: rtl/drive_arbiter_if.sv
// Requester/motor bus of the drive arbiter: mode, IR and camera commands in,
// per-wheel PWM duty and direction plus grant/busy status out.
interface drive_arbiter_if;
    logic [1:0] mode;
    logic       ir_valid;
    logic [2:0] ir_cmd;
    logic       cam_valid;
    logic [2:0] cam_cmd;
    logic [1:0] gear;
    logic       estop;
    logic [7:0] duty_l;
    logic [7:0] duty_r;
    logic       dir_l;
    logic       dir_r;
    logic [1:0] grant;
    logic       busy;

    modport slave (
        input  mode, ir_valid, ir_cmd, cam_valid, cam_cmd, gear, estop,
        output duty_l, duty_r, dir_l, dir_r, grant, busy
    );
    modport master (
        output mode, ir_valid, ir_cmd, cam_valid, cam_cmd, gear, estop,
        input  duty_l, duty_r, dir_l, dir_r, grant, busy
    );
endinterface

// File: rtl/drive_arbiter.sv
// Chooses IR or camera as the motor requester, turns its latched command into
// per-wheel duty/direction targets and ramps the PWM duty toward them safely.
module drive_arbiter #(
    parameter int RAMP_DIV  = 4,
    parameter int RAMP_STEP = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    drive_arbiter_if.slave bus
);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [7:0]       STEP8    = 8'(RAMP_STEP);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_CAM  = 2'd1;
    localparam logic [1:0] SRC_IR   = 2'd2;

    localparam logic [2:0] C_STOP   = 3'd0;
    localparam logic [2:0] C_FWD    = 3'd1;
    localparam logic [2:0] C_SPIN_L = 3'd2;
    localparam logic [2:0] C_SPIN_R = 3'd3;
    localparam logic [2:0] C_ARC_L  = 3'd4;
    localparam logic [2:0] C_ARC_R  = 3'd5;
    localparam logic [2:0] C_REV    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWITCH, S_ESTOP} state_e;

    state_e            state_q, state_d;
    logic [1:0]        src_q, src_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              seen_q, seen_d;
    logic [DIV_W-1:0]  div_q;
    logic              tick;

    // Wheel index 0 is left, 1 is right.
    logic [1:0][7:0]   duty_q, duty_d, tgt_duty, eff, mag, stp;
    logic [1:0]        dir_q, dir_d, tgt_dir;

    logic [1:0]        mode_eff;
    logic              acc_valid;
    logic [2:0]        acc_cmd;
    logic              sel_stop;
    logic [7:0]        speed, half;

    function automatic logic is_stop(input logic [2:0] c);
        return (c == 3'd0) || (c == 3'd7);
    endfunction

    assign mode_eff  = (bus.mode == 2'd3) ? SRC_NONE : bus.mode;
    assign acc_valid = ((src_q == SRC_CAM) && bus.cam_valid) ||
                       ((src_q == SRC_IR)  && bus.ir_valid);
    assign acc_cmd   = (src_q == SRC_IR) ? bus.ir_cmd : bus.cam_cmd;
    // ESTOP release listens to whichever source the mode currently selects.
    assign sel_stop  = ((mode_eff == SRC_IR)  && bus.ir_valid  && is_stop(bus.ir_cmd)) ||
                       ((mode_eff == SRC_CAM) && bus.cam_valid && is_stop(bus.cam_cmd));
    assign tick      = (div_q == DIV_LAST);
    assign speed     = {bus.gear, 6'h3f};
    assign half      = {1'b0, bus.gear, 5'h1f};

    always_comb begin
        tgt_duty = '0;
        tgt_dir  = dir_q;
        if (state_q == S_RUN) begin
            case (cmd_q)
                C_FWD:    begin tgt_duty[0] = speed; tgt_duty[1] = speed; tgt_dir = 2'b11; end
                C_REV:    begin tgt_duty[0] = speed; tgt_duty[1] = speed; tgt_dir = 2'b00; end
                C_SPIN_L: begin tgt_duty[0] = speed; tgt_duty[1] = speed; tgt_dir = 2'b10; end
                C_SPIN_R: begin tgt_duty[0] = speed; tgt_duty[1] = speed; tgt_dir = 2'b01; end
                C_ARC_L:  begin tgt_duty[0] = half;  tgt_duty[1] = speed; tgt_dir = 2'b11; end
                C_ARC_R:  begin tgt_duty[0] = speed; tgt_duty[1] = half;  tgt_dir = 2'b11; end
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cmd_d   = cmd_q;
        wd_d    = '0;
        seen_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mode_eff != SRC_NONE) begin
                    state_d = S_RUN;
                    src_d   = mode_eff;
                    cmd_d   = C_STOP;
                end
            end
            S_RUN: begin
                wd_d = wd_q;
                if (acc_valid) begin
                    cmd_d = acc_cmd;
                    wd_d  = '0;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_q == WD_LAST) cmd_d = C_STOP;
                end
                if (bus.estop)                state_d = S_ESTOP;
                else if (mode_eff != src_q)   state_d = S_SWITCH;
            end
            S_SWITCH: begin
                if (bus.estop)                state_d = S_ESTOP;
                else if (duty_q == '0)        state_d = S_IDLE;
            end
            S_ESTOP: begin
                cmd_d  = C_STOP;
                seen_d = !bus.estop && (seen_q || sel_stop);
                if (!bus.estop && (seen_q || sel_stop)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A wheel whose direction must flip first ramps to zero, flips there,
    // and only climbs again on a later tick.
    always_comb begin
        eff    = '0;
        mag    = '0;
        stp    = '0;
        duty_d = duty_q;
        dir_d  = dir_q;
        for (int w = 0; w < 2; w++) begin
            eff[w] = (tgt_dir[w] != dir_q[w]) ? 8'd0 : tgt_duty[w];
            mag[w] = (eff[w] > duty_q[w]) ? eff[w] - duty_q[w] : duty_q[w] - eff[w];
            stp[w] = (mag[w] > STEP8) ? STEP8 : mag[w];
            if (state_d == S_ESTOP)
                duty_d[w] = '0;
            else if (tick)
                duty_d[w] = (eff[w] > duty_q[w]) ? duty_q[w] + stp[w] : duty_q[w] - stp[w];
            if ((duty_q[w] == '0) && (tgt_dir[w] != dir_q[w]))
                dir_d[w] = tgt_dir[w];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= SRC_NONE;
            cmd_q   <= C_STOP;
            wd_q    <= '0;
            seen_q  <= 1'b0;
            div_q   <= '0;
            duty_q  <= '0;
            dir_q   <= 2'b11;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cmd_q   <= cmd_d;
            wd_q    <= wd_d;
            seen_q  <= seen_d;
            div_q   <= tick ? '0 : div_q + 1'b1;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.duty_l = duty_q[0];
    assign bus.duty_r = duty_q[1];
    assign bus.dir_l  = dir_q[0];
    assign bus.dir_r  = dir_q[1];
    assign bus.grant  = (state_q == S_RUN) ? src_q : SRC_NONE;
    assign bus.busy   = (state_q == S_SWITCH) || (state_q == S_ESTOP);
endmodule
